// File: rtl/officer_unlock.sv
// officer_unlock: debounced two-button code entry with gap timeout, error lockout and sticky unlock.
module officer_unlock #(
    parameter int CLK_FREQ = 48_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int TIMEOUT_MS = 2000,
    parameter int LOCKOUT_MS = 5000,
    parameter int MAX_ERRORS = 3,
    parameter int CODE_LEN = 8,
    parameter logic [CODE_LEN-1:0] CODE = 8'b10110010,
    localparam int W = $clog2(CODE_LEN + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_a,
    input  logic         btn_b,
    output logic         got_commanding_officer,
    output logic [W-1:0] progress,
    output logic         locked_out
);
    localparam int CYC = CLK_FREQ / 1000;
    localparam int DEB = DEBOUNCE_MS * CYC;
    localparam int TO = TIMEOUT_MS * CYC;
    localparam int LOCK = LOCKOUT_MS * CYC;
    localparam int TMAX = (TO > LOCK) ? TO : LOCK;
    localparam int DW = $clog2(DEB + 1);
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, ENTRY, LOCKOUT, UNLOCKED} state_t;

    logic [1:0] r_s1, r_s2, r_deb_q, w_deb, w_press;
    state_t r_state, w_state;
    logic [W-1:0] r_prog, w_prog;
    logic [2:0] r_err, w_err;
    logic [TW-1:0] r_timer, w_timer;
    logic r_got, r_lock;
    logic [CODE_LEN-1:0] w_shift;
    logic w_ev, w_good;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_deb_q <= '0;
        end else begin
            r_s1 <= {btn_b, btn_a};
            r_s2 <= r_s1;
            r_deb_q <= w_deb;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_deb
            logic [DW-1:0] r_cnt;
            logic r_deb;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_s2[g] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DW'(DEB - 1)) begin
                    r_cnt <= '0;
                    r_deb <= r_s2[g];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_deb[g] = r_deb;
        end
    endgenerate

    // bit 1 = button B (symbol 1), bit 0 = button A (symbol 0); both at once is never correct
    assign w_press = w_deb & ~r_deb_q;
    assign w_ev = |w_press;
    assign w_shift = CODE << r_prog;
    assign w_good = (w_press == 2'b10) ? w_shift[CODE_LEN-1] :
                    (w_press == 2'b01) ? ~w_shift[CODE_LEN-1] : 1'b0;

    always_comb begin
        w_state = r_state;
        w_prog = r_prog;
        w_err = r_err;
        w_timer = (r_timer == TW'(TMAX)) ? r_timer : r_timer + 1'b1;
        case (r_state)
            IDLE, ENTRY: begin
                if (w_ev) begin
                    w_timer = '0;
                    if (w_good) begin
                        w_err = '0;
                        w_prog = r_prog + 1'b1;
                        w_state = (W'(r_prog + 1'b1) == W'(CODE_LEN)) ? UNLOCKED : ENTRY;
                    end else begin
                        w_prog = '0;
                        w_err = (r_err + 3'd1 == 3'(MAX_ERRORS)) ? 3'd0 : r_err + 3'd1;
                        w_state = (r_err + 3'd1 == 3'(MAX_ERRORS)) ? LOCKOUT : IDLE;
                    end
                end else if (r_state == ENTRY && r_timer == TW'(TO - 1)) begin
                    w_state = IDLE;
                    w_prog = '0;
                end
            end
            LOCKOUT: w_state = (r_timer == TW'(LOCK - 1)) ? IDLE : LOCKOUT;
            default: w_state = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prog <= '0;
            r_err <= '0;
            r_timer <= '0;
            r_got <= 1'b0;
            r_lock <= 1'b0;
        end else begin
            r_state <= w_state;
            r_prog <= w_prog;
            r_err <= w_err;
            r_timer <= w_timer;
            r_got <= (w_state == UNLOCKED);
            r_lock <= (w_state == LOCKOUT);
        end
    end

    assign got_commanding_officer = r_got;
    assign progress = r_prog;
    assign locked_out = r_lock;
endmodule

// File: tb/tb_officer_unlock.sv
// tb_officer_unlock: table vectors, hand-written corner sequences and a symbol-level random model.
module tb_officer_unlock;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic got;
    logic [2:0] prog;
    logic lock;
    int total = 0;
    int bad = 0;
    int now_cyc = 0;

    always #5 clk = ~clk;

    officer_unlock #(
        .CLK_FREQ(10_000), .DEBOUNCE_MS(1), .TIMEOUT_MS(5), .LOCKOUT_MS(8),
        .MAX_ERRORS(3), .CODE_LEN(4), .CODE(4'b1011)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b),
        .got_commanding_officer(got), .progress(prog), .locked_out(lock)
    );

    typedef struct {
        bit a;
        bit b;
        int hold;
        int gap;
        int ep;
        int el;
        int eg;
    } vec_t;
    vec_t tbl[8];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            now_cyc++;
        end
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input int ep, input int el, input int eg);
        chk({nm, ".progress"}, int'(prog), ep);
        chk({nm, ".locked_out"}, int'(lock), el);
        chk({nm, ".got"}, int'(got), eg);
    endtask

    task automatic press(input bit a, input bit b, input int hold, input int gap);
        btn_a = a;
        btn_b = b;
        tick(hold);
        btn_a = 1'b0;
        btn_b = 1'b0;
        tick(gap);
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        tick(1);
        chk3(nm, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    bit [3:0] code = 4'b1011;
    int m_prog, m_err, last_ev;
    bit m_got, m_lock;

    task automatic model_sym(input bit a, input bit b);
        if (m_got) return;
        if (!a && b && code[3-m_prog] || a && !b && !code[3-m_prog]) begin
            m_prog++;
            m_err = 0;
            if (m_prog == 4) m_got = 1;
        end else begin
            m_prog = 0;
            m_err++;
            if (m_err == 3) begin
                m_lock = 1;
                m_err = 0;
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 1, 5, 20, 0, 0, 0};
        tbl[1] = '{0, 1, 20, 20, 1, 0, 0};
        tbl[2] = '{1, 1, 20, 20, 0, 0, 0};
        tbl[3] = '{0, 1, 20, 20, 1, 0, 0};
        tbl[4] = '{1, 0, 20, 20, 2, 0, 0};
        tbl[5] = '{0, 1, 20, 20, 3, 0, 0};
        tbl[6] = '{0, 1, 20, 20, 4, 0, 1};
        tbl[7] = '{1, 0, 20, 20, 4, 0, 1};

        tick(3);
        chk3("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            press(tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].gap);
            chk3($sformatf("tbl%0d", i), tbl[i].ep, tbl[i].el, tbl[i].eg);
        end

        do_reset("rst_pre_t1");
        press(0, 1, 20, 20);
        press(1, 0, 20, 20);
        press(0, 1, 20, 20);
        btn_b = 1'b1;
        tick(12);
        chk3("t1.before", 3, 0, 0);
        tick(1);
        chk3("t1.after", 4, 0, 1);
        btn_b = 1'b0;
        tick(200);
        chk3("t1.sticky", 4, 0, 1);

        do_reset("rst_pre_t3");
        press(0, 1, 20, 20);
        press(1, 0, 20, 0);
        chk3("t3.entry", 2, 0, 0);
        tick(30);
        chk3("t3.held", 2, 0, 0);
        tick(20);
        chk3("t3.timeout", 0, 0, 0);

        do_reset("rst_pre_t4");
        press(1, 0, 20, 20);
        chk3("t4.err1", 0, 0, 0);
        press(1, 0, 20, 20);
        chk3("t4.err2", 0, 0, 0);
        press(1, 0, 12, 0);
        press(0, 1, 12, 0);
        press(1, 0, 12, 0);
        press(0, 1, 12, 12);
        press(0, 1, 12, 0);
        chk3("t4.locked", 0, 1, 0);
        tick(10);
        chk3("t4.still", 0, 1, 0);
        tick(15);
        chk3("t4.exit", 0, 0, 0);
        press(0, 1, 20, 20);
        press(1, 0, 20, 20);
        press(0, 1, 20, 20);
        press(0, 1, 20, 20);
        chk3("t4.unlock", 4, 0, 1);
        do_reset("t6.unlocked");

        tick(5);
        press(0, 1, 20, 20);
        chk3("t5.first", 1, 0, 0);
        press(1, 1, 20, 20);
        chk3("t5.both", 0, 0, 0);
        press(1, 0, 20, 20);
        chk3("t5.err2", 0, 0, 0);
        press(1, 0, 20, 20);
        chk3("t5.err3", 0, 1, 0);
        do_reset("t6.lockout");
        tick(5);
        chk3("t6.after", 0, 0, 0);

        m_prog = 0; m_err = 0; m_got = 0; m_lock = 0; last_ev = 0;
        for (int k = 0; k < 60; k++) begin
            int r;
            int op;
            r = $urandom_range(0, 9);
            if (r < 5) op = (!m_got && code[3-m_prog]) ? 1 : 0;
            else if (r < 7) op = $urandom_range(0, 2);
            else op = r - 4;
            if (op <= 2) begin
                int ev;
                ev = now_cyc + 13;
                if (m_prog > 0 && !m_got && ev - last_ev >= 51) m_prog = 0;
                press(op != 1, op != 0, 20, 20);
                model_sym(op != 1, op != 0);
                last_ev = ev;
            end else if (op == 3) begin
                btn_b = 1'b1;
                tick(5);
                btn_b = 1'b0;
                tick(10);
            end else if (op == 4) begin
                tick(80);
            end else begin
                do_reset("rand.reset");
                m_prog = 0; m_err = 0; m_got = 0; m_lock = 0;
            end
            if (m_prog > 0 && !m_got && now_cyc - last_ev >= 51) m_prog = 0;
            chk3($sformatf("rand%0d", k), m_prog, int'(m_lock), int'(m_got));
            if (m_lock) begin
                tick(70);
                m_lock = 0;
                chk3($sformatf("rand%0d.lockend", k), m_prog, 0, int'(m_got));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
